// File: rtl/piso_bit_serializer_if.sv
// Load/serial bus for piso_bit_serializer.
// Build option: PARITY_EN. When it is defined, the block sends a parity bit after each word.
// Signals:
//   load_valid  upstream has a word on load_data
//   load_ready  block can accept a word this cycle (combinational)
//   load_data   WIDTH-bit word; sampled only on the accept edge
//   ser_out     registered serial bit
//   ser_valid   registered; high while ser_out carries a data or parity bit
//   done        registered; pulses while the final bit of a word is on ser_out
interface piso_bit_serializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             ser_out;
    logic             ser_valid;
    logic             done;

    modport master (
        output load_valid, load_data,
        input  load_ready, ser_out, ser_valid, done
    );

    modport slave (
        input  load_valid, load_data,
        output load_ready, ser_out, ser_valid, done
    );
endinterface

// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out stage. It accepts a WIDTH-bit word over valid/ready
// and shifts the word out one bit per clock. Back-to-back words leave no gap.
// Between words, ser_out is held at IDLE_BIT.
// Optional macro PARITY_EN: one even-parity bit follows each word.
// Ports: clk, rst (async active-low), bus (piso_bit_serializer_if.slave).
module piso_bit_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    piso_bit_serializer_if.slave    bus
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
`ifdef PARITY_EN
        PAR   = 2'd2,
`endif
        SHIFT = 2'd1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             done_q, done_d;
`ifdef PARITY_EN
    logic             par_q, par_d;
`endif
    logic             ready_c;
    logic             accept_c;

    assign bus.load_ready = ready_c;
    assign bus.ser_out    = ser_out_q;
    assign bus.ser_valid  = ser_valid_q;
    assign bus.done       = done_q;
    assign accept_c       = bus.load_valid & ready_c;

    // Ready is asserted in idle and on the final cycle of a word, so the next word can follow without a gap.
    always_comb begin
        ready_c = 1'b0;
        case (state_q)
            IDLE:    ready_c = 1'b1;
`ifdef PARITY_EN
            PAR:     ready_c = 1'b1;
            SHIFT:   ready_c = 1'b0;
`else
            SHIFT:   ready_c = (cnt_q == LAST);
`endif
            default: ready_c = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sh_q        <= '0;
            ser_out_q   <= IDLE_BIT;
            ser_valid_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            done_q      <= done_d;
`ifdef PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    // Next-state and next-output logic. By default the stage goes idle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        ser_out_d   = IDLE_BIT;
        ser_valid_d = 1'b0;
        done_d      = 1'b0;
`ifdef PARITY_EN
        par_d       = par_q;
`endif
        if (accept_c) begin
            // The first bit goes out now. The rest of the word is held in sh, zero-filled.
            state_d     = SHIFT;
            cnt_d       = '0;
            ser_valid_d = 1'b1;
            if (MSB_FIRST) begin
                ser_out_d = bus.load_data[WIDTH-1];
                sh_d      = bus.load_data << 1;
            end else begin
                ser_out_d = bus.load_data[0];
                sh_d      = bus.load_data >> 1;
            end
`ifdef PARITY_EN
            par_d       = ^bus.load_data;
`endif
        end else begin
            case (state_q)
                SHIFT: begin
                    if (cnt_q != LAST) begin
                        cnt_d       = CW'(cnt_q + CW'(1));
                        ser_valid_d = 1'b1;
                        if (MSB_FIRST) begin
                            ser_out_d = sh_q[WIDTH-1];
                            sh_d      = sh_q << 1;
                        end else begin
                            ser_out_d = sh_q[0];
                            sh_d      = sh_q >> 1;
                        end
`ifndef PARITY_EN
                        done_d      = (cnt_q == PRE_LAST);
`endif
                    end else begin
`ifdef PARITY_EN
                        state_d     = PAR;
                        ser_out_d   = par_q;
                        ser_valid_d = 1'b1;
                        done_d      = 1'b1;
`else
                        state_d     = IDLE;
`endif
                        cnt_d       = '0;
                    end
                end
`ifdef PARITY_EN
                PAR:     state_d = IDLE;
`endif
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: doc/piso_bit_serializer.md
Name: piso_bit_serializer

Overview:
- Parallel-in/serial-out stage that feeds a one-bit-per-clock stream into the serial sequence-detector FSMs.
- Accepts a WIDTH-bit word over a valid/ready handshake, then drives it out one bit per clock on ser_out.
- Supports gapless back-to-back words so the downstream detector sees a continuous stream.
- Drives a fixed idle level between words so the downstream detector is never fed undefined bits.

Parameters:
- WIDTH, 8: word length in bits; legal range is 2 to 32.
- MSB_FIRST, 1: 1 means bit WIDTH-1 is sent first; 0 means bit 0 is sent first.
- IDLE_BIT, 1'b1: level driven on ser_out when no data bit is being sent.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- load_valid  input  1  upstream has a word on load_data.
- load_ready  output  1  block can accept a word this cycle.
- load_data  input  WIDTH  word to serialize; sampled only on the accept edge.
- ser_out  output  1  registered serial bit to the downstream detector.
- ser_valid  output  1  registered; 1 while ser_out carries a data or parity bit.
- done  output  1  registered one-cycle pulse in the cycle the final bit of a word is on ser_out.

Behaviour:
- Reset (rst low, asynchronous):
  - ser_out = IDLE_BIT, ser_valid = 0, done = 0.
  - State = IDLE, bit counter = 0, shift register = 0.
  - No transfer occurs while rst is low.
- States: IDLE, SHIFT (plus PAR when PARITY_EN is defined).
- load_ready is combinational:
  - 1 in IDLE.
  - 1 in SHIFT when the counter is WIDTH-1 and PARITY_EN is undefined.
  - 1 in PAR.
  - 0 otherwise.
- Accept = load_valid AND load_ready at a rising edge. On the accept edge:
  - ser_out <= first bit (per MSB_FIRST); ser_valid <= 1.
  - Remaining bits are loaded into the shift register; counter <= 0; state <= SHIFT.
- Latency: the first bit appears on ser_out in the cycle after the accept edge.
- In SHIFT, each edge without a new accept:
  - If counter < WIDTH-1: counter increments, ser_out <= next bit.
  - If counter = WIDTH-1 (last bit currently shown): go to IDLE, ser_out <= IDLE_BIT, ser_valid <= 0. With PARITY_EN, go to PAR instead.
- done is high exactly in the cycle the last data bit is on ser_out. With PARITY_EN, done is high in the cycle the parity bit is on ser_out instead.
- Back-to-back words: an accept on the last-bit edge starts the next word on the next cycle. ser_valid stays 1 and there is no idle bit between words.
- load_valid while load_ready = 0 is ignored. The upstream must hold load_valid and load_data stable until accepted.
- The counter is $clog2(WIDTH) bits wide and never exceeds WIDTH-1.
- Reset mid-word aborts immediately: outputs return to their reset values and no partial word resumes after reset release.
- Bits shifted out past the end of the word are not observable; shift fill is 0.

Optional Feature:
- Macro: PARITY_EN.
- Defined:
  - After the last data bit, one extra cycle in state PAR drives the even-parity bit, XOR of all WIDTH data bits, with ser_valid = 1 and done = 1.
  - A word occupies WIDTH+1 cycles; back-to-back accept is allowed only in PAR.
- Undefined: no PAR state; a word occupies WIDTH cycles.

Test Plan:
1. Reset: rst = 0 with load_valid = 1 -> ser_out = 1, ser_valid = 0, done = 0, load_ready = 1, and no word is accepted after release until a new valid edge.
2. WIDTH = 8, MSB_FIRST = 1, accept 8'hA5 at edge k -> ser_out = 1,0,1,0,0,1,0,1 on cycles k+1..k+8. ser_valid = 1 for those 8 cycles, done = 1 only at k+8, then ser_out = 1 and ser_valid = 0.
3. Back-to-back: load_valid held with 8'h0F then 8'hF0 -> 16 contiguous bits 0000111111110000. ser_valid never drops, done pulses at the 8th and 16th bit, and load_ready is high only in idle and last-bit cycles.
4. MSB_FIRST = 0, accept 8'h01 -> ser_out = 1,0,0,0,0,0,0,0. load_valid asserted with 8'h55 at bit 3 is not accepted until the last-bit cycle.
5. Reset mid-word: accept 8'hFF, drop rst after 3 bits -> ser_out = 1, ser_valid = 0, done = 0 immediately. A new accept of 8'h00 then emits 8 zeros from the start.
6. PARITY_EN defined: accept 8'h07 -> 8 data bits followed by parity bit 1 (three ones). done is high on the parity cycle only, and the word occupies 9 cycles.
